// File: rtl/freecell_move_sequencer.sv
// freecell_move_sequencer
//   Queues FreeCell moves from a host and feeds them one at a time to the
//   freecell player's source/dest inputs. It inserts NOP gap cycles between
//   moves and stops when the player wins, when the queue drains, or when the
//   move limit is reached.
//
// Optional feature: define FREECELL_SEQ_FILTER_EN to drop entries whose source
//   is a home cell (11xx) or whose source equals dest. Dropped entries are
//   counted on reject_count; that port exists only when the macro is defined.
//
// Ports
//   clock, reset        single clock; synchronous active-high reset
//   push_valid/push_move/push_ready   move FIFO write side {source, dest}
//   start, pause, win   run control and the player's win flag
//   source, dest        registered move to the player (NOP = 4'hC / 4'hC)
//   busy, done, won, timeout          run status
//   move_count          moves issued this run (saturating)
//   fifo_count          entries currently queued
//   reject_count        (filter build only) entries dropped by the filter

module freecell_move_sequencer #(
  parameter int unsigned DEPTH      = 64,
  parameter int unsigned GAP_CYCLES = 1,
  parameter int unsigned MAX_MOVES  = 200,
  parameter int unsigned COUNT_W    = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         push_valid,
  input  logic [7:0]                   push_move,
  output logic                         push_ready,
  input  logic                         start,
  input  logic                         pause,
  input  logic                         win,
  output logic [3:0]                   source,
  output logic [3:0]                   dest,
  output logic                         busy,
  output logic                         done,
  output logic                         won,
  output logic                         timeout,
  output logic [COUNT_W-1:0]           move_count,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count
`ifdef FREECELL_SEQ_FILTER_EN
  ,
  output logic [7:0]                   reject_count
`endif
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned FcW  = $clog2(DEPTH + 1);
  localparam logic [3:0]  Nop  = 4'b1100;
  // GAP holds for GAP_CYCLES cycles; the down-counter is loaded one short
  // because the exit test happens on the counter reaching zero.
  localparam logic [3:0]  GapLoad = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);
  localparam bit          HasGap  = (GAP_CYCLES != 0);
  localparam logic [COUNT_W-1:0] MaxCount = COUNT_W'(MAX_MOVES);

  typedef enum logic [2:0] {
    StIdle,
    StRun,
    StGap,
    StPause,
    StDone,
    StWon
  } state_e;

  state_e               state_q, state_d;
  logic [7:0]           mem_q [DEPTH];
  logic [PtrW-1:0]      rd_ptr_q, wr_ptr_q;
  logic [FcW-1:0]       fcount_q;
  logic [3:0]           src_q, src_d, dst_q, dst_d;
  logic [3:0]           gap_q, gap_d;
  logic [COUNT_W-1:0]   mcount_q, mcount_d;
  logic                 timeout_q, timeout_d;
  logic                 push_acc, pop, fifo_empty, reject, clr_rej, inc_rej;
  logic [7:0]           head;

  assign push_ready = (fcount_q < FcW'(DEPTH));
  assign push_acc   = push_valid && push_ready;
  assign fifo_empty = (fcount_q == '0);
  assign head       = mem_q[rd_ptr_q];

`ifdef FREECELL_SEQ_FILTER_EN
  assign reject = (head[7:6] == 2'b11) || (head[7:4] == head[3:0]);
`else
  assign reject = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    src_d     = Nop;
    dst_d     = Nop;
    gap_d     = gap_q;
    mcount_d  = mcount_q;
    timeout_d = timeout_q;
    pop       = 1'b0;
    clr_rej   = 1'b0;
    inc_rej   = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d   = StRun;
          mcount_d  = '0;
          timeout_d = 1'b0;
          clr_rej   = 1'b1;
        end
      end
      StRun: begin
        if (win) begin
          state_d = StWon;
        end else if (pause) begin
          state_d = StPause;
        end else if (mcount_q == MaxCount) begin
          state_d   = StDone;
          timeout_d = 1'b1;
        end else if (fifo_empty) begin
          state_d = StDone;
        end else begin
          pop = 1'b1;
          if (reject) begin
            // Filtered entry: consumed silently, next entry may go next cycle.
            inc_rej = 1'b1;
          end else begin
            src_d = head[7:4];
            dst_d = head[3:0];
            if (mcount_q != {COUNT_W{1'b1}}) mcount_d = mcount_q + COUNT_W'(1);
            if (HasGap) begin
              state_d = StGap;
              gap_d   = GapLoad;
            end
          end
        end
      end
      StGap: begin
        if (win) begin
          state_d = StWon;
        end else if (gap_q == 4'd0) begin
          state_d = StRun;
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end
      StPause: begin
        if (win) begin
          state_d = StWon;
        end else if (!pause) begin
          state_d = StRun;
        end
      end
      StWon: begin
        state_d = StWon;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      fcount_q  <= '0;
      src_q     <= Nop;
      dst_q     <= Nop;
      gap_q     <= 4'd0;
      mcount_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      gap_q     <= gap_d;
      mcount_q  <= mcount_d;
      timeout_q <= timeout_d;
      if (push_acc) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)      rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push_acc && !pop) begin
        fcount_q <= fcount_q + FcW'(1);
      end else if (pop && !push_acc) begin
        fcount_q <= fcount_q - FcW'(1);
      end
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clock) begin
    if (push_acc) mem_q[wr_ptr_q] <= push_move;
  end

`ifdef FREECELL_SEQ_FILTER_EN
  logic [7:0] rej_q;
  always_ff @(posedge clock) begin
    if (reset || clr_rej) begin
      rej_q <= 8'd0;
    end else if (inc_rej && rej_q != 8'hFF) begin
      rej_q <= rej_q + 8'd1;
    end
  end
  assign reject_count = rej_q;
`endif

  assign source     = src_q;
  assign dest       = dst_q;
  assign busy       = (state_q == StRun) || (state_q == StGap) || (state_q == StPause);
  assign done       = (state_q == StDone) || (state_q == StWon);
  assign won        = (state_q == StWon);
  assign timeout    = timeout_q;
  assign move_count = mcount_q;
  assign fifo_count = fcount_q;

endmodule

// File: tb/tb_freecell_move_sequencer.sv
module tb_freecell_move_sequencer;

  localparam int Depth = 64;

  logic        clock = 1'b0;
  logic        reset;
  logic        push_valid, start, pause, win;
  logic [7:0]  push_move;
  logic        push_ready, busy, done, won, timeout;
  logic [3:0]  source, dest;
  logic [15:0] move_count;
  logic [6:0]  fifo_count;

  // Second instance with a small move limit and a two-cycle gap.
  logic        m_push_valid, m_start;
  logic [7:0]  m_push_move;
  logic        m_push_ready, m_busy, m_done, m_won, m_timeout;
  logic [3:0]  m_source, m_dest;
  logic [15:0] m_move_count;
  logic [4:0]  m_fifo_count;
  logic        m_pause, m_win;
`ifdef FREECELL_SEQ_FILTER_EN
  logic [7:0]  reject_count, m_reject_count;
`endif

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$], issued[$], exp4[$], issued4[$];

  always #5 clock = ~clock;

  freecell_move_sequencer #(.DEPTH(64), .GAP_CYCLES(1), .MAX_MOVES(200), .COUNT_W(16)) dut (
    .clock(clock), .reset(reset), .push_valid(push_valid), .push_move(push_move),
    .push_ready(push_ready), .start(start), .pause(pause), .win(win),
    .source(source), .dest(dest), .busy(busy), .done(done), .won(won),
    .timeout(timeout), .move_count(move_count), .fifo_count(fifo_count)
`ifdef FREECELL_SEQ_FILTER_EN
    , .reject_count(reject_count)
`endif
  );

  freecell_move_sequencer #(.DEPTH(16), .GAP_CYCLES(2), .MAX_MOVES(4), .COUNT_W(16)) dut4 (
    .clock(clock), .reset(reset), .push_valid(m_push_valid), .push_move(m_push_move),
    .push_ready(m_push_ready), .start(m_start), .pause(m_pause), .win(m_win),
    .source(m_source), .dest(m_dest), .busy(m_busy), .done(m_done), .won(m_won),
    .timeout(m_timeout), .move_count(m_move_count), .fifo_count(m_fifo_count)
`ifdef FREECELL_SEQ_FILTER_EN
    , .reject_count(m_reject_count)
`endif
  );

  // Any non-NOP value on source/dest is one issued move.
  always @(negedge clock) begin
    if (!reset && {source, dest} != 8'hCC) issued.push_back({source, dest});
    if (!reset && {m_source, m_dest} != 8'hCC) issued4.push_back({m_source, m_dest});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Random legal-looking move: source never a home cell, dest differs from source.
  function automatic logic [7:0] rand_move();
    logic [3:0] s, d;
    s = 4'($urandom_range(0, 11));
    d = 4'($urandom_range(0, 15));
    if (d == s) d = s ^ 4'h1;
    return {s, d};
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    push_valid = 1'b0; push_move = 8'h00; start = 1'b0; pause = 1'b0; win = 1'b0;
    m_push_valid = 1'b0; m_push_move = 8'h00; m_start = 1'b0; m_pause = 1'b0; m_win = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    exp_q.delete(); issued.delete(); exp4.delete(); issued4.delete();
  endtask

  // Pushes made while the sequencer is not popping; the model accepts up to Depth.
  task automatic push(input logic [7:0] m);
    push_valid = 1'b1;
    push_move  = m;
    if (exp_q.size() < Depth) exp_q.push_back(m);
    tick();
    push_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk("wait_done", done, 1);
  endtask

  task automatic wait_issues(input int want, input int budget, output int seen);
    int n = 0;
    seen = 0;
    while (seen < want && n < budget) begin
      tick();
      n++;
      if ({source, dest} != 8'hCC) seen++;
    end
  endtask

  task automatic check_issued(input int n);
    chk("issued_size", issued.size(), n);
    for (int i = 0; i < n; i++)
      chk("issued_move", (i < issued.size()) ? {24'h0, issued[i]} : 32'hFFFF_FFFF, exp_q[i]);
  endtask

  initial begin
    int seen;
    logic [7:0] x;

    // Reset values
    do_reset();
    chk("rst_source", source, 4'hC);
    chk("rst_dest", dest, 4'hC);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_won", won, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_move_count", move_count, 0);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_push_ready", push_ready, 1);

    // Directed three-move run, plus a push landing on the first pop cycle
    push(8'h68); push(8'h59); push(8'h5C);
    chk("s1_fifo3", fifo_count, 3);
    pulse_start();
    chk("s1_busy", busy, 1);
    chk("s1_nop_run", {source, dest}, 8'hCC);
    x = rand_move();
    push_valid = 1'b1; push_move = x; exp_q.push_back(x);
    tick();
    push_valid = 1'b0;
    chk("s1_mv0", {source, dest}, 8'h68);
    chk("s1_pushpop_count", fifo_count, 3);
    tick(); chk("s1_gap0", {source, dest}, 8'hCC);
    tick(); chk("s1_mv1", {source, dest}, 8'h59);
    tick(); chk("s1_gap1", {source, dest}, 8'hCC);
    tick(); chk("s1_mv2", {source, dest}, 8'h5C);
    tick(); chk("s1_gap2", {source, dest}, 8'hCC);
    tick(); chk("s1_mv3", {source, dest}, x);
    tick();
    tick();
    chk("s1_done", done, 1);
    chk("s1_busy_off", busy, 0);
    chk("s1_move_count", move_count, 4);
    chk("s1_fifo_empty", fifo_count, 0);
    chk("s1_timeout", timeout, 0);
    check_issued(4);

    // Full FIFO: 65th push dropped; push on the first pop cycle also dropped
    do_reset();
    for (int i = 0; i < Depth; i++) push(rand_move());
    chk("s2_full_ready", push_ready, 0);
    chk("s2_full_count", fifo_count, Depth);
    push(rand_move());
    chk("s2_drop_count", fifo_count, Depth);
    pulse_start();
    push_valid = 1'b1; push_move = rand_move();
    tick();
    push_valid = 1'b0;
    chk("s2_first_pop", fifo_count, Depth - 1);
    chk("s2_ready_again", push_ready, 1);
    wait_done(400);
    chk("s2_move_count", move_count, Depth);
    check_issued(Depth);

    // Win during the gap after move 2 of 5
    do_reset();
    for (int i = 0; i < 5; i++) push(rand_move());
    pulse_start();
    wait_issues(2, 50, seen);
    chk("s3_seen2", seen, 2);
    win = 1'b1;
    tick();
    win = 1'b0;
    chk("s3_won", won, 1);
    chk("s3_done", done, 1);
    chk("s3_busy", busy, 0);
    pulse_start();
    tick(); tick(); tick();
    chk("s3_won_held", won, 1);
    chk("s3_fifo", fifo_count, 3);
    chk("s3_move_count", move_count, 2);
    chk("s3_nop", {source, dest}, 8'hCC);
    check_issued(2);

    // Pause mid-run holds NOP and pops nothing
    do_reset();
    for (int i = 0; i < 6; i++) push(rand_move());
    pulse_start();
    wait_issues(1, 50, seen);
    chk("s4_seen1", seen, 1);
    pause = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("s4_pause_nop", {source, dest}, 8'hCC);
      chk("s4_pause_fifo", fifo_count, 5);
    end
    pause = 1'b0;
    wait_done(100);
    chk("s4_move_count", move_count, 6);
    check_issued(6);

    // Reset asserted mid-gap
    do_reset();
    for (int i = 0; i < 3; i++) push(rand_move());
    pulse_start();
    wait_issues(1, 50, seen);
    chk("s5_seen1", seen, 1);
    reset = 1'b1;
    tick();
    chk("s5_rst_src", {source, dest}, 8'hCC);
    chk("s5_rst_fifo", fifo_count, 0);
    chk("s5_rst_busy", busy, 0);
    chk("s5_rst_count", move_count, 0);
    chk("s5_rst_ready", push_ready, 1);
    reset = 1'b0;

    // Move limit of 4 with 10 queued, run twice
    do_reset();
    for (int i = 0; i < 10; i++) begin
      x = rand_move();
      m_push_valid = 1'b1; m_push_move = x; exp4.push_back(x);
      tick();
    end
    m_push_valid = 1'b0;
    for (int r = 0; r < 2; r++) begin
      int n = 0;
      m_start = 1'b1;
      tick();
      m_start = 1'b0;
      chk("s6_timeout_clr", m_timeout, 0);
      chk("s6_count_clr", m_move_count, 0);
      while (m_done !== 1'b1 && n < 100) begin
        tick();
        n++;
      end
      chk("s6_done", m_done, 1);
      chk("s6_timeout", m_timeout, 1);
      chk("s6_move_count", m_move_count, 4);
      chk("s6_fifo", m_fifo_count, 6 - 4 * r);
      chk("s6_issued_size", issued4.size(), 4 * (r + 1));
      for (int i = 0; i < 4 * (r + 1); i++)
        chk("s6_issued_move", (i < issued4.size()) ? {24'h0, issued4[i]} : 32'hFFFF_FFFF, exp4[i]);
    end

`ifdef FREECELL_SEQ_FILTER_EN
    // Filter drops a home-cell source and a self-move
    do_reset();
    push(8'hC0); push(8'h33); push(8'h12);
    pulse_start();
    wait_done(50);
    chk("s7_issued_size", issued.size(), 1);
    chk("s7_issued", (issued.size() > 0) ? {24'h0, issued[0]} : 32'hFFFF_FFFF, 8'h12);
    chk("s7_reject", reject_count, 2);
    chk("s7_move_count", move_count, 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
